// File: rtl/score_keeper.sv
// Pong-style score keeper: start edge detection, serve-delay timing, per-player
// scoring and game-over hold. Every output comes straight from a register.
module score_keeper #(
  parameter int MAXSCORE    = 9,
  parameter int SERVE_DELAY = 50000000,
  parameter int DLY_W       = 26
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_goal0,
  input  logic       i_goal1,
  output logic       o_running,
  output logic [3:0] o_score0,
  output logic [3:0] o_score1,
  output logic       o_serve,
  output logic       o_serve_dir
);

  localparam logic [DLY_W-1:0] RELOAD = DLY_W'(SERVE_DELAY - 1);
  localparam logic [3:0]       MAX_SC = 4'(MAXSCORE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SERVE_WAIT,
    S_PLAY,
    S_GAME_OVER
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_start_prev;
  logic [DLY_W-1:0] r_cnt;
  logic [DLY_W-1:0] w_cnt_next;
  logic [3:0]       r_score0;
  logic [3:0]       r_score1;
  logic [3:0]       w_score0_next;
  logic [3:0]       w_score1_next;
  logic             r_running;
  logic             w_running_next;
  logic             r_serve;
  logic             w_serve_next;
  logic             r_serve_dir;
  logic             w_serve_dir_next;

  logic             w_start_edge;
  logic             w_goal0_only;
  logic             w_goal1_only;
  logic             w_goal_both;
  logic [3:0]       w_score0_inc;
  logic [3:0]       w_score1_inc;

  assign w_start_edge = i_start & ~r_start_prev;
  assign w_goal0_only = i_goal0 & ~i_goal1;
  assign w_goal1_only = i_goal1 & ~i_goal0;
  assign w_goal_both  = i_goal0 & i_goal1;
  assign w_score0_inc = r_score0 + 4'd1;
  assign w_score1_inc = r_score1 + 4'd1;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_GAME_OVER: begin
        if (w_start_edge) w_state_next = S_SERVE_WAIT;
      end
      S_SERVE_WAIT: begin
        if (r_cnt == '0) w_state_next = S_PLAY;
      end
      S_PLAY: begin
        if (w_goal0_only) begin
          w_state_next = (w_score0_inc == MAX_SC) ? S_GAME_OVER : S_SERVE_WAIT;
        end else if (w_goal1_only) begin
          w_state_next = (w_score1_inc == MAX_SC) ? S_GAME_OVER : S_SERVE_WAIT;
        end else if (w_goal_both) begin
          w_state_next = S_SERVE_WAIT;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and the serve-delay counter.
  always_comb begin
    w_cnt_next       = r_cnt;
    w_score0_next    = r_score0;
    w_score1_next    = r_score1;
    w_serve_dir_next = r_serve_dir;
    w_serve_next     = 1'b0;
    w_running_next   = (w_state_next == S_SERVE_WAIT) || (w_state_next == S_PLAY);
    case (r_state)
      S_IDLE, S_GAME_OVER: begin
        if (w_start_edge) begin
          w_score0_next    = 4'd0;
          w_score1_next    = 4'd0;
          w_serve_dir_next = 1'b0;
          w_cnt_next       = RELOAD;
        end
      end
      S_SERVE_WAIT: begin
        if (r_cnt == '0) w_serve_next = 1'b1;
        else             w_cnt_next   = r_cnt - 1'b1;
      end
      S_PLAY: begin
        if (w_goal0_only) begin
          w_score0_next    = w_score0_inc;
          w_serve_dir_next = 1'b1;
          w_cnt_next       = RELOAD;
        end else if (w_goal1_only) begin
          w_score1_next    = w_score1_inc;
          w_serve_dir_next = 1'b0;
          w_cnt_next       = RELOAD;
        end else if (w_goal_both) begin
          w_cnt_next = RELOAD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_start_prev <= 1'b0;
      r_cnt        <= '0;
      r_score0     <= 4'd0;
      r_score1     <= 4'd0;
      r_running    <= 1'b0;
      r_serve      <= 1'b0;
      r_serve_dir  <= 1'b0;
    end else begin
      r_start_prev <= i_start;
      r_cnt        <= w_cnt_next;
      r_score0     <= w_score0_next;
      r_score1     <= w_score1_next;
      r_running    <= w_running_next;
      r_serve      <= w_serve_next;
      r_serve_dir  <= w_serve_dir_next;
    end
  end

  assign o_running   = r_running;
  assign o_score0    = r_score0;
  assign o_score1    = r_score1;
  assign o_serve     = r_serve;
  assign o_serve_dir = r_serve_dir;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with SERVE_DELAY=4, MAXSCORE=3; expected
// values are hand-derived and checked with immediate assertions.
module tb_score_keeper;

  logic       clk;
  logic       rst;
  logic       start;
  logic       goal0;
  logic       goal1;
  logic       running;
  logic [3:0] score0;
  logic [3:0] score1;
  logic       serve;
  logic       serve_dir;

  int checks;
  int failures;

  score_keeper #(
    .MAXSCORE   (3),
    .SERVE_DELAY(4),
    .DLY_W      (4)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_goal0    (goal0),
    .i_goal1    (goal1),
    .o_running  (running),
    .o_score0   (score0),
    .o_score1   (score1),
    .o_serve    (serve),
    .o_serve_dir(serve_dir)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic e_run, input logic [3:0] e0,
                             input logic [3:0] e1, input logic e_srv, input logic e_dir);
    check({tag, ".running"}, 32'(running), 32'(e_run));
    check({tag, ".score0"}, 32'(score0), 32'(e0));
    check({tag, ".score1"}, 32'(score1), 32'(e1));
    check({tag, ".serve"}, 32'(serve), 32'(e_srv));
    check({tag, ".dir"}, 32'(serve_dir), 32'(e_dir));
    $display("step %s: running=%0b score0=%0d score1=%0d serve=%0b dir=%0b",
             tag, running, score0, score1, serve, serve_dir);
  endtask

  // Four cycles of SERVE_WAIT; the serve pulse must appear on the fourth.
  // Optionally fires stray goals during the wait, including the cycle just before the serve.
  task automatic serve_wait(input string tag, input logic e_dir, input logic [3:0] e0,
                            input logic [3:0] e1, input logic inject);
    for (int i = 1; i <= 4; i++) begin
      if (inject && i == 2) goal1 = 1'b1;
      if (inject && i == 4) goal0 = 1'b1;
      tick();
      goal0 = 1'b0;
      goal1 = 1'b0;
      check({tag, ".serve_t"}, 32'(serve), 32'(i == 4));
      check({tag, ".running_t"}, 32'(running), 32'd1);
    end
    check_state(tag, 1'b1, e0, e1, 1'b1, e_dir);
    tick();
    check({tag, ".serve_one_cycle"}, 32'(serve), 32'd0);
  endtask

  task automatic goal(input logic g0, input logic g1);
    goal0 = g0;
    goal1 = g1;
    tick();
    goal0 = 1'b0;
    goal1 = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    goal0    = 1'b0;
    goal1    = 1'b0;
    tick();
    tick();
    check_state("reset", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_state("idle", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

    // Start pulse, then first serve with stray goals during the wait.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_state("start", 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
    serve_wait("serve1", 1'b0, 4'd0, 4'd0, 1'b1);

    // Start edge during PLAY is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_state("start_in_play", 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);

    goal(1'b1, 1'b0);
    check_state("goal0_a", 1'b1, 4'd1, 4'd0, 1'b0, 1'b1);
    serve_wait("serve2", 1'b1, 4'd1, 4'd0, 1'b0);

    goal(1'b1, 1'b1);
    check_state("both_goals", 1'b1, 4'd1, 4'd0, 1'b0, 1'b1);
    serve_wait("reserve", 1'b1, 4'd1, 4'd0, 1'b0);

    goal(1'b0, 1'b1);
    check_state("goal1_a", 1'b1, 4'd1, 4'd1, 1'b0, 1'b0);
    serve_wait("serve3", 1'b0, 4'd1, 4'd1, 1'b0);

    goal(1'b1, 1'b0);
    check_state("goal0_b", 1'b1, 4'd2, 4'd1, 1'b0, 1'b1);
    serve_wait("serve4", 1'b1, 4'd2, 4'd1, 1'b0);

    // Winning goal: running falls in the same cycle, scores frozen afterwards.
    goal(1'b1, 1'b0);
    check_state("win", 1'b0, 4'd3, 4'd1, 1'b0, 1'b1);
    goal(1'b1, 1'b0);
    goal(1'b0, 1'b1);
    tick();
    check_state("game_over_hold", 1'b0, 4'd3, 4'd1, 1'b0, 1'b1);

    // New game from GAME_OVER, score once, then reset asynchronously mid-wait.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_state("restart", 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
    serve_wait("serve5", 1'b0, 4'd0, 4'd0, 1'b0);
    goal(1'b0, 1'b1);
    check_state("goal1_b", 1'b1, 4'd0, 4'd1, 1'b0, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_state("async_reset", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_reset.serve", 32'(serve), 32'd0);
      check("post_reset.running", 32'(running), 32'd0);
    end

    // Start held high through reset release starts a game on the first clock.
    rst   = 1'b1;
    start = 1'b1;
    tick();
    tick();
    check_state("held_start_in_reset", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_state("held_start_release", 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
    serve_wait("serve6", 1'b0, 4'd0, 4'd0, 1'b0);
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter MAXSCORE, default 9: winning score; legal range 1..15.
REQ-002 Parameter SERVE_DELAY, default 50000000: number of clock cycles between a point (or game start) and the next serve; legal range 1..2^DLY_W-1.
REQ-003 Parameter DLY_W, default 26: width of the serve-delay counter.
REQ-004 clock  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  player start button, level; only its rising edge acts.
REQ-007 goal0  input  1  one-cycle pulse from ball logic: player 0 scored (ball passed player 1).
REQ-008 goal1  input  1  one-cycle pulse from ball logic: player 1 scored (ball passed player 0).
REQ-009 running  output  1  high in SERVE_WAIT and PLAY; feeds the score display stage.
REQ-010 score0  output  4  player 0 score, unsigned.
REQ-011 score1  output  4  player 1 score, unsigned.
REQ-012 serve  output  1  one-cycle pulse: ball logic shall launch the ball.
REQ-013 serveDir  output  1  launch direction when serve is high: 0 = toward player 0, 1 = toward player 1.

Function
REQ-014 The FSM SHALL have four states: IDLE, SERVE_WAIT, PLAY, GAME_OVER; all outputs are registered.
REQ-015 Start edge: startPrev is registered each cycle; startEdge = start & ~startPrev.
REQ-016 IDLE or GAME_OVER, startEdge -> next cycle: SERVE_WAIT, score0 = score1 = 0, serveDir = 0, delay counter = SERVE_DELAY-1.
REQ-017 startEdge in SERVE_WAIT or PLAY SHALL be ignored.
REQ-018 SERVE_WAIT: counter decrements by 1 per cycle; when counter == 0 -> next cycle PLAY with serve = 1 for exactly that cycle; SERVE_WAIT therefore lasts exactly SERVE_DELAY cycles.
REQ-019 serve SHALL be 0 in every cycle other than the first cycle of PLAY.
REQ-020 PLAY, goal0 only -> next cycle: score0 + 1, serveDir = 1 (serve toward the player who conceded).
REQ-021 PLAY, goal1 only -> next cycle: score1 + 1, serveDir = 0.
REQ-022 After a scoring goal, if the new score equals MAXSCORE -> GAME_OVER; otherwise -> SERVE_WAIT with counter reloaded to SERVE_DELAY-1.
REQ-023 PLAY, goal0 and goal1 asserted in the same cycle -> no score change, serveDir unchanged, -> SERVE_WAIT (re-serve).
REQ-024 goal0/goal1 outside PLAY SHALL be ignored, including during the serve cycle's predecessor in SERVE_WAIT.
REQ-025 running SHALL be 1 exactly when state is SERVE_WAIT or PLAY; running falls in the same cycle GAME_OVER is entered.
REQ-026 GAME_OVER SHALL hold score0/score1 unchanged (one equals MAXSCORE) until startEdge or reset, so the downstream display shows the winner.
REQ-027 Scores SHALL never exceed MAXSCORE; no wrap-around is reachable.

Reset
REQ-028 reset asserted -> immediately, independent of clock: state IDLE, score0 = 0, score1 = 0, running = 0, serve = 0, serveDir = 0, counter = 0, startPrev = 0.
REQ-029 reset asserted mid-SERVE_WAIT or mid-PLAY SHALL abandon the game with no serve pulse; after release, a fresh startEdge is required.
REQ-030 start held high through reset release: startPrev = 0, so the first clock after release detects an edge and the game starts.

Verification (SERVE_DELAY = 4, MAXSCORE = 3)
REQ-031 Reset, then pulse start -> running = 1 next cycle; serve = 1 exactly 4 cycles later with serveDir = 0; score0 = score1 = 0.
REQ-032 In PLAY pulse goal0 -> score0 = 1, serveDir = 1, running stays 1, serve pulses 4 cycles later.
REQ-033 Drive goal0 three times (each in PLAY) -> after the third, score0 = 3, running = 0, state GAME_OVER; further goal0/goal1 pulses leave scores unchanged.
REQ-034 In PLAY pulse goal0 and goal1 together -> scores unchanged, re-serve after 4 cycles with prior serveDir.
REQ-035 Goal pulse during SERVE_WAIT and start pulse during PLAY -> no effect on scores, state, or serve timing.
REQ-036 Assert reset asynchronously mid-SERVE_WAIT (between clock edges) -> outputs at reset values before the next edge; no serve pulse follows.
